// File: rtl/nec_tx_pkg.sv
// Shared NEC timing constants and transmitter state encoding.
// The receiver imports the same unit counts so both sides agree on frame timing.
package nec_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_REP_SPACE  = 3'd5,
        ST_STOP_MARK  = 3'd6,
        ST_GAP        = 3'd7
    } nec_tx_state_t;

    localparam int NEC_LEAD_MARK_T  = 16;
    localparam int NEC_LEAD_SPACE_T = 8;
    localparam int NEC_REP_SPACE_T  = 4;
    localparam int NEC_ONE_SPACE_T  = 3;
    localparam int NEC_ZERO_SPACE_T = 1;
    localparam int NEC_BITS         = 32;

    function automatic logic is_mark(input nec_tx_state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_tx_carrier.sv
// Carrier phase generator. Exposes the carrier level for the *next* cycle so the
// top can register ir_out without adding a cycle of lag at mark start.
module nec_carrier #(
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 439
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_restart,
    output logic o_carrier_next
);

    localparam int PW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
    localparam logic [PW:0] HIGH_W = (PW + 1)'(CARRIER_HIGH);

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;

    always_comb begin
        w_phase_next = r_phase + 1'b1;
        if (i_restart || (r_phase == PW'(CARRIER_PERIOD - 1))) begin
            w_phase_next = '0;
        end
    end

    assign o_carrier_next = ({1'b0, w_phase_next} < HIGH_W);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

endmodule

// File: rtl/nec_tx.sv
// NEC IR transmitter: full frames (ADDR, ~ADDR, cmd, ~cmd, LSB-first) or repeat
// codes, envelope optionally modulated by a carrier, followed by a guard gap.
module nec_tx
    import nec_tx_pkg::*;
#(
    parameter logic [7:0] ADDR           = 8'h00,
    parameter int         TICK_CYCLES    = 28125,
    parameter int         CARRIER_PERIOD = 1316,
    parameter int         CARRIER_HIGH   = 439,
    parameter logic       CARRIER_EN     = 1'b1,
    parameter int         GAP_TICKS      = 72
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_in,
    input  logic       data_in_en,
    input  logic       repeat_in_en,
    output logic       busy,
    output logic       ir_out
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    nec_tx_state_t r_state;
    nec_tx_state_t w_state_next;

    logic [TW-1:0] r_tick_cnt;
    logic [6:0]    r_unit_cnt;
    logic [5:0]    r_bit_cnt;
    logic [31:0]   r_shift;
    logic          r_is_rep;
    logic          r_ir_out;

    logic       w_tick;
    logic [6:0] w_len;
    logic       w_last;
    logic       w_accept;
    logic       w_state_change;
    logic       w_restart;
    logic       w_carrier_next;

    assign w_tick         = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_accept       = (r_state == ST_IDLE) && (data_in_en || repeat_in_en);
    assign w_state_change = (w_state_next != r_state);
    assign w_restart      = is_mark(w_state_next) && w_state_change;
    assign w_last         = w_tick && (r_unit_cnt == (w_len - 7'd1));

    always_comb begin
        w_len = 7'd1;
        case (r_state)
            ST_LEAD_MARK:  w_len = 7'(NEC_LEAD_MARK_T);
            ST_LEAD_SPACE: w_len = 7'(NEC_LEAD_SPACE_T);
            ST_BIT_SPACE:  w_len = r_shift[0] ? 7'(NEC_ONE_SPACE_T) : 7'(NEC_ZERO_SPACE_T);
            ST_REP_SPACE:  w_len = 7'(NEC_REP_SPACE_T);
            ST_GAP:        w_len = 7'(GAP_TICKS);
            default:       w_len = 7'd1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept) w_state_next = ST_LEAD_MARK;
            ST_LEAD_MARK:  if (w_last) w_state_next = r_is_rep ? ST_REP_SPACE : ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (w_last) w_state_next = ST_BIT_MARK;
            ST_BIT_MARK:   if (w_last) w_state_next = ST_BIT_SPACE;
            ST_BIT_SPACE:  if (w_last) w_state_next = (r_bit_cnt == 6'(NEC_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
            ST_REP_SPACE:  if (w_last) w_state_next = ST_STOP_MARK;
            ST_STOP_MARK:  if (w_last) w_state_next = ST_GAP;
            ST_GAP:        if (w_last) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    nec_carrier #(
        .CARRIER_PERIOD (CARRIER_PERIOD),
        .CARRIER_HIGH   (CARRIER_HIGH)
    ) u_carrier (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .i_restart      (w_restart),
        .o_carrier_next (w_carrier_next)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_unit_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_is_rep   <= 1'b0;
            r_ir_out   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == ST_IDLE) || w_state_change) begin
                r_tick_cnt <= '0;
                r_unit_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= '0;
                r_unit_cnt <= r_unit_cnt + 7'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            // A full-frame strobe takes priority over a simultaneous repeat strobe.
            if (w_accept) begin
                r_shift   <= {~data_in, data_in, ~ADDR, ADDR};
                r_bit_cnt <= '0;
                r_is_rep  <= !data_in_en;
            end else if ((r_state == ST_BIT_SPACE) && w_last) begin
                r_shift   <= {1'b0, r_shift[31:1]};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            // Driven from the next state so the LED turns on the cycle after accept.
            r_ir_out <= is_mark(w_state_next) && (CARRIER_EN ? w_carrier_next : 1'b1);
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign ir_out = r_ir_out;

endmodule

// File: tb/tb_nec_tx.sv
// Bench for nec_tx: two instances (carrier off / on) share stimulus; a per-cycle
// expectation queue {busy, busy_c, env, carrier_out} is filled on each strobe.
module tb_nec_tx;

    localparam int TC  = 4;
    localparam int GAP = 5;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] data_in;
    logic       data_in_en;
    logic       repeat_in_en;
    logic       busy, ir_out, busy_c, ir_out_c;

    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    nec_tx #(
        .ADDR(8'h00), .TICK_CYCLES(TC), .CARRIER_PERIOD(3), .CARRIER_HIGH(1),
        .CARRIER_EN(1'b0), .GAP_TICKS(GAP)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in),
        .data_in_en(data_in_en), .repeat_in_en(repeat_in_en),
        .busy(busy), .ir_out(ir_out)
    );

    nec_tx #(
        .ADDR(8'h00), .TICK_CYCLES(TC), .CARRIER_PERIOD(3), .CARRIER_HIGH(1),
        .CARRIER_EN(1'b1), .GAP_TICKS(GAP)
    ) dut_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in),
        .data_in_en(data_in_en), .repeat_in_en(repeat_in_en),
        .busy(busy_c), .ir_out(ir_out_c)
    );

    // Carrier pattern within a mark: 1,0,0 repeating from mark start.
    task automatic push_seg(input logic lvl, input int units);
        for (int c = 0; c < units * TC; c++) begin
            exp_q.push_back({1'b1, 1'b1, lvl, lvl && ((c % 3) == 0)});
        end
    endtask

    task automatic push_idle(input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(4'b0000);
    endtask

    task automatic push_frame(input logic [7:0] cmd, input int idle_n);
        logic [31:0] w;
        w = {~cmd, cmd, 8'hFF, 8'h00};
        push_seg(1'b1, 16);
        push_seg(1'b0, 8);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, 1);
            push_seg(1'b0, w[i] ? 3 : 1);
        end
        push_seg(1'b1, 1);
        push_seg(1'b0, GAP);
        push_idle(idle_n);
    endtask

    task automatic push_repeat(input int idle_n);
        push_seg(1'b1, 16);
        push_seg(1'b0, 4);
        push_seg(1'b1, 1);
        push_seg(1'b0, GAP);
        push_idle(idle_n);
    endtask

    // Called at a negedge; strobe is captured at the following posedge.
    task automatic send(input logic full, input logic rep, input logic [7:0] d, input int idle_n);
        data_in      = d;
        data_in_en   = full;
        repeat_in_en = rep;
        if (full) push_frame(d, idle_n);
        else if (rep) push_repeat(idle_n);
        @(negedge sys_clk);
        data_in_en   = 1'b0;
        repeat_in_en = 1'b0;
    endtask

    task automatic check_stream(input string name, input int inject_at, input int rst_at);
        int         idx   = 0;
        int         shown = 0;
        logic [3:0] e;
        logic [3:0] got;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {busy, busy_c, ir_out, ir_out_c};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                if (shown < 5)
                    $display("FAIL %s cycle=%0d busy/busy_c/ir/ir_c got=%b expected=%b", name, idx, got, e);
                shown++;
            end
            if (idx == inject_at) begin
                data_in    = 8'h12;
                data_in_en = 1'b1;
            end else begin
                data_in_en = 1'b0;
            end
            if (idx == rst_at) begin
                sys_rst = 1'b1;
                @(negedge sys_clk);
                n_checks++;
                got = {busy, busy_c, ir_out, ir_out_c};
                if (got !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL %s_reset cycle=%0d busy/busy_c/ir/ir_c got=%b expected=0000", name, idx, got);
                end
                sys_rst = 1'b0;
                exp_q.delete();
            end else begin
                @(negedge sys_clk);
            end
            idx++;
        end
        $display("%s: stream checked, %0d cycles", name, idx);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; data_in = 8'h00; data_in_en = 1'b0; repeat_in_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        push_idle(4);
        check_stream("reset", -1, -1);
    endtask

    task automatic test_full_frame();
        send(1'b1, 1'b0, 8'h45, 8);
        check_stream("frame_45", -1, -1);
    endtask

    task automatic test_repeat();
        send(1'b0, 1'b1, 8'h00, 8);
        check_stream("repeat", -1, -1);
    endtask

    task automatic test_drop_while_busy();
        send(1'b1, 1'b0, 8'h45, 12);
        check_stream("drop_busy", 300, -1);
    endtask

    task automatic test_both_strobes();
        send(1'b1, 1'b1, 8'h07, 8);
        check_stream("both_07", -1, -1);
    endtask

    task automatic test_back_to_back();
        send(1'b0, 1'b1, 8'h00, 0);
        check_stream("b2b_first", -1, -1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle busy got=%b expected=0", busy);
        end
        send(1'b1, 1'b0, 8'hA5, 8);
        check_stream("b2b_second", -1, -1);
    endtask

    task automatic test_reset_midframe();
        send(1'b1, 1'b0, 8'hC3, 0);
        check_stream("rst_mid", -1, 200);
        push_idle(3);
        check_stream("rst_idle", -1, -1);
        send(1'b1, 1'b0, 8'h3C, 8);
        check_stream("after_rst", -1, -1);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_repeat();
        test_drop_while_busy();
        test_both_strobes();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
